// File: rtl/wb_crc32.sv
// Wishbone slave CRC-32 accelerator: seed/init the CRC, stream bytes into DATA
// (one byte folded per clock), read the final value from RESULT.
module wb_crc32 #(
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic        wb_err
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_SEED   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [1:0]  adr_q, adr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] seed_q, seed_d;

  logic        req;
  logic [1:0]  lane;
  logic [3:0]  sel_left;
  logic [7:0]  fold_byte;
  logic [31:0] fold_out;
  logic        unused_adr;

  assign req        = wb_cyc & wb_stb;
  assign wb_err     = 1'b0;
  assign unused_adr = ^{wb_adr[31:4], wb_adr[1:0]};

  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  // sel_q holds the lanes still to fold; the lowest remaining lane goes next.
  always_comb begin
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (sel_q[i]) lane = 2'(i);
    end
  end

  assign sel_left  = sel_q & ~(4'b0001 << lane);
  assign fold_byte = dat_q[{lane, 3'b000} +: 8];
  assign fold_out  = crc_fold(crc_q, fold_byte);

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    crc_d    = crc_q;
    seed_d   = seed_q;
    wb_ack   = 1'b0;
    wb_stall = 1'b1;
    wb_dat_o = 32'h0;
    case (state_q)
      S_IDLE: begin
        wb_stall = 1'b0;
        if (req) begin
          adr_d   = wb_adr[3:2];
          we_d    = wb_we;
          sel_d   = wb_sel;
          dat_d   = wb_dat_i;
          state_d = (wb_we && wb_adr[3:2] == REG_DATA && wb_sel != 4'h0) ? S_BUSY : S_ACK;
        end
      end
      S_BUSY: begin
        crc_d = fold_out;
        sel_d = sel_left;
        if (sel_left == 4'h0) state_d = S_ACK;
      end
      S_ACK: begin
        wb_ack  = 1'b1;
        state_d = S_IDLE;
        sel_d   = 4'h0;
        if (we_q) begin
          case (adr_q)
            REG_CTRL: begin
              if (dat_q[1])      crc_d = INIT;
              else if (dat_q[0]) crc_d = seed_q;
            end
            REG_SEED: begin
              for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) seed_d[8*i +: 8] = dat_q[8*i +: 8];
              end
            end
            default: ;
          endcase
        end else begin
          case (adr_q)
            REG_CTRL:   wb_dat_o = 32'h0;
            REG_SEED:   wb_dat_o = seed_q;
            REG_DATA:   wb_dat_o = crc_q;
            REG_RESULT: wb_dat_o = crc_q ^ XOROUT;
            default:    wb_dat_o = 32'h0;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      adr_q   <= 2'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      dat_q   <= 32'h0;
      crc_q   <= INIT;
      seed_q  <= INIT;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      crc_q   <= crc_d;
      seed_q  <= seed_d;
    end
  end

endmodule
